// File: rtl/enc_pkg.sv
// Shared constants and types for the registered 4-to-2 encoder.
// Pure declarations; no logic, no latency, no flow control.
package enc_pkg;

    localparam int N_IN  = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] enc_idx_t;

    localparam enc_idx_t IDX_NONE = 2'b00;

    // One registered encoder result; cleared value is all-zero.
    typedef struct packed {
        enc_idx_t idx;
        logic     valid;
        logic     multi;
    } enc_out_t;

    localparam enc_out_t ENC_OUT_CLR = '{idx: IDX_NONE, valid: 1'b0, multi: 1'b0};

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-input priority encoder: highest set line wins.
// Zero latency; no flow control.
module prio_enc4
    import enc_pkg::*;
(
    input  logic [N_IN-1:0] in,
    output enc_idx_t        idx,
    output logic            any,
    output logic            multi
);

    always_comb begin
        idx = IDX_NONE;
        unique casez (in)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            4'b0001: idx = 2'd0;
            4'b0000: idx = IDX_NONE;
            default: idx = IDX_NONE;
        endcase
    end

    assign any = |in;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi = |(in & (in - 4'd1));

endmodule

// File: rtl/encoder_4x2.sv
// Registered 4-to-2 priority encoder with valid and multi-request flags.
// One-cycle latency from sampled inputs; en=0 holds outputs, sync rst clears them.
module encoder_4x2
    import enc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic y0,
    output logic y1,
    output logic valid,
    output logic multi
);

    logic [N_IN-1:0] req;
    enc_idx_t        enc_idx;
    logic            enc_any;
    logic            enc_multi;
    enc_out_t        out_d;
    enc_out_t        out_q;

    assign req = {i3, i2, i1, i0};

    prio_enc4 u_prio_enc4 (
        .in    (req),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d.idx   = enc_idx;
            out_d.valid = enc_any;
            out_d.multi = enc_multi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= ENC_OUT_CLR;
        end else begin
            out_q <= out_d;
        end
    end

    assign y1    = out_q.idx[1];
    assign y0    = out_q.idx[0];
    assign valid = out_q.valid;
    assign multi = out_q.multi;

endmodule

// File: tb/tb_encoder_4x2.sv
// Self-checking bench for encoder_4x2: directed scenarios plus randomized traffic
// against a behavioural model of highest-set-line encoding.
module tb_encoder_4x2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic i0  = 1'b0;
    logic i1  = 1'b0;
    logic i2  = 1'b0;
    logic i3  = 1'b0;
    logic y0, y1, valid, multi;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {y1,y0,valid,multi} held by the reference model.
    logic [3:0] exp_q = 4'b0000;
    logic [3:0] obs;

    encoder_4x2 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .y0    (y0),
        .y1    (y1),
        .valid (valid),
        .multi (multi)
    );

    always #5 clk = ~clk;

    // Reference: scan lines low to high, last set line is the winner; count set lines.
    function automatic logic [3:0] ref_encode(input logic [3:0] r);
        int win;
        int cnt;
        win = 0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (r[k]) begin
                win = k;
                cnt = cnt + 1;
            end
        end
        ref_encode = {win[1:0], (cnt > 0), (cnt > 1)};
    endfunction

    // Drive one cycle of stimulus, advance past the edge and update the model.
    task automatic apply(input logic r, input logic e, input logic [3:0] req);
        rst = r;
        en  = e;
        {i3, i2, i1, i0} = req;
        @(posedge clk);
        #1;
        if (r)      exp_q = 4'b0000;
        else if (e) exp_q = ref_encode(req);
        obs = {y1, y0, valid, multi};
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'($urandom), 4'($urandom));
            n_checks++;
            if (obs !== 4'b0000)
                $display("FAIL reset_cyc%0d got=%b want=0000", c, obs);
            else
                n_pass++;
        end
    endtask

    task automatic test_onehot();
        logic [3:0] want [4] = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, 4'(1 << k));
            n_checks++;
            if (obs !== want[k])
                $display("FAIL onehot_i%0d got=%b want=%b", k, obs, want[k]);
            else
                n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] reqs [3] = '{4'b1001, 4'b0011, 4'b1111};
        logic [3:0] want [3] = '{4'b1111, 4'b0111, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b1, reqs[k]);
            n_checks++;
            if (obs !== want[k])
                $display("FAIL priority_req%b got=%b want=%b", reqs[k], obs, want[k]);
            else
                n_pass++;
        end
    endtask

    task automatic test_no_request();
        apply(1'b0, 1'b1, 4'b1000);
        apply(1'b0, 1'b1, 4'b0000);
        n_checks++;
        if (obs !== 4'b0000)
            $display("FAIL no_request got=%b want=0000", obs);
        else
            n_pass++;
    endtask

    task automatic test_enable_hold();
        apply(1'b0, 1'b1, 4'b0100);
        n_checks++;
        if (obs !== 4'b1010) $display("FAIL hold_load got=%b want=1010", obs);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 4'b0010);
            n_checks++;
            if (obs !== 4'b1010) $display("FAIL hold_cyc%0d got=%b want=1010", c, obs);
            else n_pass++;
        end
        apply(1'b0, 1'b1, 4'b0010);
        n_checks++;
        if (obs !== 4'b0110) $display("FAIL hold_release got=%b want=0110", obs);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        apply(1'b0, 1'b1, 4'b1000);
        n_checks++;
        if (obs !== 4'b1110) $display("FAIL midrst_load got=%b want=1110", obs);
        else n_pass++;
        apply(1'b1, 1'b1, 4'b1000);
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL midrst_clear got=%b want=0000", obs);
        else n_pass++;
        apply(1'b0, 1'b1, 4'b1000);
        n_checks++;
        if (obs !== 4'b1110) $display("FAIL midrst_resume got=%b want=1110", obs);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            apply(($urandom_range(15) == 0), 1'($urandom), 4'($urandom));
            n_checks++;
            if (obs !== exp_q)
                $display("FAIL random_cyc%0d req=%b got=%b want=%b",
                         c, {i3, i2, i1, i0}, obs, exp_q);
            else
                n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_priority();
        test_no_request();
        test_enable_hold();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
